instr_mem_loader: RTL

- Parametrised successor to the single-port synchronous instruction memory.
- Adds a streaming load engine with a valid/ready handshake and an auto-incrementing, wrapping address counter.
- Adds a fetch port with an explicit output-valid flag and an arbitrated stall against loads.
- Sits between the program loader (host/testbench DMA) and the core's fetch stage; replaces the raw wen/addr interface.

---
 rtl/instr_mem_loader_pkg.sv | 14 +
 rtl/instr_mem_loader_array.sv | 37 +++
 rtl/instr_mem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction memory loader: load FSM states and instruction word type.
package instr_mem_loader_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    typedef logic [INSTR_WIDTH-1:0] instruction_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/instr_mem_loader_array.sv
// Single-port synchronous RAM: one write or one read per cycle, registered read data.
module instr_mem_loader_array #(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned width_p      = 32
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_wen,
    input  logic                    i_ren,
    input  logic [addr_width_p-1:0] i_addr,
    input  logic [width_p-1:0]      i_wdata,
    output logic [width_p-1:0]      o_rdata
);

    localparam int unsigned DEPTH = 1 << addr_width_p;

    logic [width_p-1:0] r_mem [DEPTH];
    logic [width_p-1:0] r_rdata;

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_ren) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with streaming load engine and stall-arbitrated fetch port.
// Define INSTR_MEM_LOADER_PARITY_EN to store an even-parity bit per word and expose parity_err_o.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned addr_width_p  = 10,
    parameter int unsigned instr_width_p = INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     fetch_v_i,
    input  logic [addr_width_p-1:0]  fetch_addr_i,
    output logic                     fetch_ready_o,
    output logic                     instr_v_o,
    output logic [instr_width_p-1:0] instr_o,
    input  logic                     load_start_i,
    input  logic [addr_width_p-1:0]  load_base_i,
    input  logic [addr_width_p:0]    load_len_i,
    input  logic                     load_v_i,
    input  logic [instr_width_p-1:0] load_data_i,
    output logic                     load_ready_o,
    output logic                     load_busy_o,
    output logic                     load_done_o
`ifdef INSTR_MEM_LOADER_PARITY_EN
    ,
    output logic                     parity_err_o
`endif
);

`ifdef INSTR_MEM_LOADER_PARITY_EN
    localparam int unsigned MEM_W = instr_width_p + 1;
`else
    localparam int unsigned MEM_W = instr_width_p;
`endif

    load_state_e             r_state;
    logic [addr_width_p-1:0] r_addr;
    logic [addr_width_p:0]   r_rem;
    logic                    r_load_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_instr_v;

    logic                    w_beat;
    logic                    w_fetch_acc;
    logic [addr_width_p-1:0] w_mem_addr;
    logic [MEM_W-1:0]        w_wdata;
    logic [MEM_W-1:0]        w_rdata;

    // r_load_ready mirrors (r_state == LOAD), so a beat is also the write-wins condition.
    assign w_beat        = r_load_ready && load_v_i;
    assign fetch_ready_o = reset_n_i && !w_beat;
    assign w_fetch_acc   = fetch_v_i && fetch_ready_o;
    assign w_mem_addr    = w_beat ? r_addr : fetch_addr_i;

`ifdef INSTR_MEM_LOADER_PARITY_EN
    assign w_wdata      = {^load_data_i, load_data_i};
    assign parity_err_o = r_instr_v && (^w_rdata);
`else
    assign w_wdata      = load_data_i;
`endif

    instr_mem_loader_array #(
        .addr_width_p (addr_width_p),
        .width_p      (MEM_W)
    ) u_array (
        .clk     (clk),
        .i_rst_n (reset_n_i),
        .i_wen   (w_beat),
        .i_ren   (w_fetch_acc),
        .i_addr  (w_mem_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_rem        <= '0;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_instr_v    <= 1'b0;
        end else begin
            r_instr_v <= w_fetch_acc;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (load_start_i) begin
                        r_busy <= 1'b1;
                        if (load_len_i != '0) begin
                            r_addr       <= load_base_i;
                            r_rem        <= load_len_i;
                            r_load_ready <= 1'b1;
                            r_state      <= LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (w_beat) begin
                        r_addr <= r_addr + 1'b1;
                        r_rem  <= r_rem - 1'b1;
                        if (r_rem == (addr_width_p+1)'(1)) begin
                            r_load_ready <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_load_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign load_ready_o = r_load_ready;
    assign load_busy_o  = r_busy;
    assign load_done_o  = r_done;
    assign instr_v_o    = r_instr_v;
    assign instr_o      = w_rdata[instr_width_p-1:0];

endmodule
